// File: rtl/regfile_pkg.sv
// Shared register-file definitions.
// Holds the register file geometry and the maintenance sequencer state
// encoding. The register file itself and the core-side port mux use the
// same constants, so they always agree on sizes.
package regfile_pkg;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 64;  // always 2**ADDR_W

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMP  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Register file dump / clear sequencer.
// On an accepted start it either streams every register out as
// (address, data) beats over a valid/ready interface, or writes zero to
// every register. It drives the register file ports only while busy is
// high; the core muxes it in for that time.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start, mode      request and operation select (0 dump, 1 clear),
//                    both sampled only in IDLE
//   busy, done       operation in progress / one-cycle completion pulse
//   rf_read_addr     register file read address
//   rf_read_data     asynchronous read data for rf_read_addr
//   rf_write_en      register file write enable
//   rf_write_addr    register file write address
//   rf_write_data    register file write data (always zero)
//   out_valid/ready  dump stream handshake
//   out_addr/data    streamed register address and value
module regfile_dump #(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  import regfile_pkg::*;

  // Last entry is found by comparison, never by counter overflow.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] index;
  logic              handshake;
  logic              last;

  assign handshake = out_valid && out_ready;
  assign last      = (index == LAST_IDX);

  // State register.
  // NOTE: clocked state always uses non-blocking assignment so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = mode ? CLEAR : DUMP;
      DUMP:    if (handshake && last) next_state = DONE;
      CLEAR:   if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Port outputs decoded from the state. The read address runs one entry
  // ahead of the beat on display, so the next value is already on
  // rf_read_data when the current beat is accepted.
  always_comb begin
    rf_read_addr  = '0;
    rf_write_en   = 1'b0;
    rf_write_addr = '0;
    unique case (state)
      DUMP:    rf_read_addr = index + IDX_ONE;  // wraps to 0 on last entry
      CLEAR: begin
        rf_write_en   = 1'b1;
        rf_write_addr = index;
      end
      default: ;
    endcase
  end

  assign rf_write_data = '0;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // Index counter and dump stream payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      index     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            index <= '0;
            if (!mode) begin
              // Register 0 is on the read port while idle.
              out_valid <= 1'b1;
              out_addr  <= '0;
              out_data  <= rf_read_data;
            end
          end
        end
        DUMP: begin
          if (handshake) begin
            if (last) begin
              out_valid <= 1'b0;
            end else begin
              index    <= index + IDX_ONE;
              out_addr <= index + IDX_ONE;
              out_data <= rf_read_data;
            end
          end
        end
        CLEAR:   index <= last ? '0 : index + IDX_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump. Contains a behavioural register
// file (async read, clocked write, plus a preload port) and an expected
// register image that is updated from the operation rules.
module tb_regfile_dump;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NR = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, rf_write_en, out_valid;
  logic [AW-1:0] rf_read_addr, rf_write_addr, out_addr;
  logic [DW-1:0] rf_read_data, rf_write_data, out_data;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] rf       [NR];
  logic [DW-1:0] exp_regs [NR];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_dump dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .busy         (busy),
    .done         (done),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .rf_write_en  (rf_write_en),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data)
  );

  assign rf_read_data = rf[rf_read_addr];

  always @(posedge clk) begin
    if (pl_en)            rf[pl_addr]       <= pl_data;
    else if (rf_write_en) rf[rf_write_addr] <= rf_write_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_rd_addr"},    rf_read_addr, 0);
    check({tag, "_wr_en"},      rf_write_en, 0);
    check({tag, "_wr_addr"},    rf_write_addr, 0);
    check({tag, "_wr_data"},    rf_write_data, 0);
    check({tag, "_out_valid"},  out_valid, 0);
    check({tag, "_out_addr"},   out_addr, 0);
    check({tag, "_out_data"},   out_data, 0);
  endtask

  // Load the register file through the side port while the DUT is idle.
  task automatic preload(input bit pattern);
    for (int k = 0; k < NR; k++) begin
      pl_en   = 1'b1;
      pl_addr = AW'(k);
      pl_data = pattern ? 32'hA500_0000 + k : $urandom;
      exp_regs[k] = pl_data;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
  endtask

  // Issue one operation starting in an idle cycle and follow it to IDLE.
  // abort_at >= 0 asserts reset at that beat (dump) or write (clear).
  task automatic run_op(input logic m, input int ready_pct, input bit poke, input int abort_at);
    int            cyc = 0;
    int            beats = 0;
    int            writes = 0;
    int            dones = 0;
    int            done_cyc = -1;
    bit            stalled = 0;
    bit            aborted = 0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;

    start = 1'b1;
    mode  = m;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'($urandom_range(0, 1));
    cyc   = 1;
    check("busy_after_start", busy, 1);
    check("valid_after_start", out_valid, !m);

    while (busy && cyc <= 2000 && !aborted) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      start     = poke && (cyc == 5 || cyc == 30);
      mode      = 1'($urandom_range(0, 1));

      if (abort_at >= 0 && !m && out_valid && beats == abort_at) begin
        reset     = 1'b1;
        out_ready = 1'b0;
        aborted   = 1;
      end

      if (out_valid && !aborted) begin
        if (stalled) begin
          check("stall_addr", out_addr, st_addr);
          check("stall_data", out_data, st_data);
        end
        if (out_ready) begin
          check("beat_addr", out_addr, beats);
          check("beat_data", out_data, exp_regs[beats]);
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          st_addr = out_addr;
          st_data = out_data;
        end
      end

      if (rf_write_en) begin
        check("write_addr", rf_write_addr, writes);
        check("write_data", rf_write_data, 0);
        if (writes < NR) exp_regs[writes] = '0;
        writes++;
        if (abort_at >= 0 && m && writes == abort_at + 1) begin
          reset   = 1'b1;
          aborted = 1;
        end
      end

      if (done) begin
        dones++;
        done_cyc = cyc;
      end

      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;

    if (cyc > 2000) check("timeout_busy", busy, 0);

    if (aborted) begin
      check_all_zero("after_reset");
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check("post_reset_wr_en", rf_write_en, 0);
        check("post_reset_busy", busy, 0);
      end
    end else begin
      check("beat_count",  beats,  m ? 0 : NR);
      check("write_count", writes, m ? NR : 0);
      check("done_count",  dones,  1);
      check("idle_done",   done, 0);
      check("idle_valid",  out_valid, 0);
      check("idle_wr_en",  rf_write_en, 0);
      if (m || ready_pct == 100) begin
        check("done_cycle", done_cyc, NR + 1);
        check("idle_cycle", cyc, NR + 2);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Known pattern, full-rate dump.
    preload(1'b1);
    run_op(1'b0, 100, 1'b0, -1);
    // Same contents under heavy backpressure; back-to-back with the last.
    run_op(1'b0, 30, 1'b0, -1);
    // Clear followed by a dump that must read all zeros.
    run_op(1'b1, 100, 1'b0, -1);
    run_op(1'b0, 100, 1'b0, -1);

    // Random contents; start pulses during busy must be ignored.
    preload(1'b0);
    run_op(1'b0, 70, 1'b1, -1);
    run_op(1'b1, 100, 1'b1, -1);
    run_op(1'b0, 100, 1'b0, -1);

    // Reset in the middle of a dump and of a clear, then a fresh dump
    // that sees registers 0..10 cleared and the rest untouched.
    preload(1'b0);
    run_op(1'b0, 50, 1'b0, 20);
    run_op(1'b1, 100, 1'b0, 10);
    run_op(1'b0, 100, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug/maintenance sequencer sitting on the far side of the processor register file's read and write ports. On a start request it either walks all registers through the read port and streams (address, data) pairs out over a valid/ready interface, or it clears every register to zero through the write port. It owns the register file ports only while `busy` is high; the core muxes it in for that time.

## Interface
- `ADDR_W`, 6, register address width
- `DATA_W`, 32, register data width
- `NUM_REGS`, 64, registers walked; must equal 2**ADDR_W
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `mode`  in  1  sampled with `start`: 0 = dump, 1 = clear
- `busy`  out  1  high from cycle after accepted start until `done`, inclusive
- `done`  out  1  one-cycle pulse at end of operation
- `rf_read_addr`  out  ADDR_W  register file read address
- `rf_read_data`  in  DATA_W  register file asynchronous read data for `rf_read_addr`, same cycle
- `rf_write_en`  out  1  register file write enable (RegWrite)
- `rf_write_addr`  out  ADDR_W  register file write address
- `rf_write_data`  out  DATA_W  register file write data; always 0
- `out_valid`  out  1  dump stream valid
- `out_ready`  in  1  dump stream ready
- `out_addr`  out  ADDR_W  address of streamed register
- `out_data`  out  DATA_W  value of streamed register

## Operation
- States: IDLE, DUMP, CLEAR, DONE.
- IDLE: `rf_read_addr` = 0. On `start`&&!`mode`: capture `rf_read_data` (reg 0) into `out_data`, `out_addr`=0, `out_valid`=1, index=0, go DUMP. On `start`&&`mode`: index=0, go CLEAR.
- DUMP: `out_valid` held high; `out_addr`/`out_data` stable until handshake (`out_valid`&&`out_ready`). `rf_read_addr` = index+1 (wraps harmlessly to 0 at last). On handshake with index<NUM_REGS-1: index+1, capture new `rf_read_data` in same edge, `out_valid` stays 1 (one transfer per cycle sustained). On handshake with index==NUM_REGS-1: `out_valid`=0, go DONE.
- CLEAR: `rf_write_en`=1, `rf_write_addr`=index, `rf_write_data`=0 combinationally; index increments each cycle; after writing NUM_REGS-1 go DONE. Exactly NUM_REGS write cycles; no backpressure.
- DONE: `done`=1 for this one cycle, `busy` still 1; next state IDLE.
- `start` outside IDLE ignored; `mode` ignored except when `start` accepted.
- Index counter is ADDR_W+0 wide; last-entry detection by compare to NUM_REGS-1, never by overflow.
- Reset (any state, including mid-dump or mid-clear): next state IDLE, index=0, `out_valid`=0, `done`=0, `busy`=0, `out_addr`=0, `out_data`=0; `rf_write_en` low in the first cycle after the reset edge (no partial write continues).

## Timing
- Reset values: all outputs 0 (`rf_read_addr`=0, `rf_write_*`=0).
- Dump: start accepted at edge N → `out_valid` high from cycle N+1; with `out_ready` tied high, 64 transfers occupy cycles N+1..N+64, `done` in N+65, IDLE at N+66.
- Clear: start at edge N → writes in cycles N+1..N+64 (addr 0..63), `done` in N+65.
- `busy` high cycles N+1 through the `done` cycle.
- `out_ready` may toggle arbitrarily; payload never changes while `out_valid`&&!`out_ready`.
- New `start` accepted earliest in the cycle after `done`.

## Structure
- Shared package `regfile_pkg`: ADDR_W, DATA_W, NUM_REGS constants and the state encoding (IDLE, DUMP, CLEAR, DONE), reused by the register file and core mux.
- Single module; no sub-module warranted (counter and FSM are a few lines each).

## Test plan
- Preload reg k = 32'hA500_0000+k, dump with `out_ready`=1 → 64 beats, addr 0..63, data A500_0000..A500_003F, `done` exactly 65 cycles after start edge.
- Dump with `out_ready` random 30% → same 64 beats in order, no duplicates/drops, payload stable while stalled.
- Clear then dump → all 64 `out_data`=0; exactly 64 `rf_write_en` cycles observed, addrs 0..63 each once.
- Pulse `start` during DUMP and CLEAR → ignored; beat/write counts unchanged, single `done`.
- Assert `reset` at beat 20 of dump and at write 10 of clear → next cycle all outputs 0, no further writes; fresh dump afterwards starts at addr 0.
- `start` in the cycle after `done` → accepted; back-to-back operations complete correctly.
